// File: rtl/aes_128_ctrl_if.sv
// Control-side link between the AES-128 sequencer and the AES-128 core.
// master = sequencer (drives key/plaintext and command pulses), slave = core.
interface aes_128_ctrl_if;
    logic [127:0] core_key;
    logic         core_key_load;
    logic         core_key_ready;
    logic [127:0] core_din;
    logic         core_start;
    logic         core_done;
    logic [127:0] core_dout;

    modport master (
        output core_key, core_key_load, core_din, core_start,
        input  core_key_ready, core_done, core_dout
    );

    modport slave (
        input  core_key, core_key_load, core_din, core_start,
        output core_key_ready, core_done, core_dout
    );
endinterface

// File: rtl/aes_128_ctrl.sv
// Sequencer between the AES-128 register slice and the AES-128 core: key-expansion caching,
// single-block encryption, ciphertext capture, sticky status flags, IRQ and timeout handling.
module aes_128_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                start,
    input  logic [127:0]        key_in,
    input  logic                key_update,
    input  logic [127:0]        data_in,
    input  logic                irq_en,
    input  logic                irq_clr,
    aes_128_ctrl_if.master      core,
    output logic [127:0]        result,
    output logic                busy,
    output logic                done,
    output logic                err_timeout,
    output logic                err_overrun,
    output logic                irq,
    output logic [CNT_W-1:0]    op_count
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY_LOAD,
        S_KEY_WAIT,
        S_ENC_START,
        S_ENC_WAIT,
        S_ABORT
    } state_t;

    state_t             state_q,       state_d;
    logic [TMR_W-1:0]   timer_q,       timer_d;
    logic               key_stale_q,   key_stale_d;
    logic [127:0]       core_key_q,    core_key_d;
    logic [127:0]       core_din_q,    core_din_d;
    logic               key_load_q,    key_load_d;
    logic               core_start_q,  core_start_d;
    logic [127:0]       result_q,      result_d;
    logic               done_q,        done_d;
    logic               err_tmo_q,     err_tmo_d;
    logic               err_ovr_q,     err_ovr_d;
    logic               irq_q,         irq_d;
    logic [CNT_W-1:0]   op_count_q,    op_count_d;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        key_stale_d   = key_stale_q | key_update;
        core_key_d    = core_key_q;
        core_din_d    = core_din_q;
        key_load_d    = 1'b0;
        core_start_d  = 1'b0;
        result_d      = result_q;
        done_d        = done_q;
        err_tmo_d     = err_tmo_q;
        err_ovr_d     = err_ovr_q;
        op_count_d    = op_count_q;

        // Clear first so that any flag set further down in the same cycle wins.
        if (irq_clr) begin
            done_d    = 1'b0;
            err_tmo_d = 1'b0;
            err_ovr_d = 1'b0;
        end

        if (start && (state_q != S_IDLE)) begin
            err_ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    core_din_d = data_in;
                    // A key write landing together with start is already in key_in.
                    if (key_stale_q || key_update) begin
                        core_key_d = key_in;
                        state_d    = S_KEY_LOAD;
                    end else begin
                        state_d    = S_ENC_START;
                    end
                end
            end

            S_KEY_LOAD: begin
                key_load_d  = 1'b1;
                key_stale_d = key_update;
                timer_d     = '0;
                state_d     = S_KEY_WAIT;
            end

            S_KEY_WAIT: begin
                // While the load pulse is still on the wire, ready reflects the previous key.
                if (core.core_key_ready && !key_load_q) begin
                    state_d = S_ENC_START;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_ENC_START: begin
                core_start_d = 1'b1;
                timer_d      = '0;
                state_d      = S_ENC_WAIT;
            end

            S_ENC_WAIT: begin
                if (core.core_done) begin
                    result_d   = core.core_dout;
                    done_d     = 1'b1;
                    op_count_d = op_count_q + CNT_W'(1);
                    state_d    = S_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    state_d = S_ABORT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            S_ABORT: begin
                err_tmo_d   = 1'b1;
                key_stale_d = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        irq_d = irq_en & (done_q | err_tmo_q | err_ovr_q);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            key_stale_q  <= 1'b1;
            core_key_q   <= '0;
            core_din_q   <= '0;
            key_load_q   <= 1'b0;
            core_start_q <= 1'b0;
            result_q     <= '0;
            done_q       <= 1'b0;
            err_tmo_q    <= 1'b0;
            err_ovr_q    <= 1'b0;
            irq_q        <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            key_stale_q  <= key_stale_d;
            core_key_q   <= core_key_d;
            core_din_q   <= core_din_d;
            key_load_q   <= key_load_d;
            core_start_q <= core_start_d;
            result_q     <= result_d;
            done_q       <= done_d;
            err_tmo_q    <= err_tmo_d;
            err_ovr_q    <= err_ovr_d;
            irq_q        <= irq_d;
            op_count_q   <= op_count_d;
        end
    end

    assign core.core_key      = core_key_q;
    assign core.core_key_load = key_load_q;
    assign core.core_din      = core_din_q;
    assign core.core_start    = core_start_q;

    assign result      = result_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err_timeout = err_tmo_q;
    assign err_overrun = err_ovr_q;
    assign irq         = irq_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_aes_128_ctrl.sv
// Directed bench for aes_128_ctrl: a behavioural core stub plus a vector table and
// hand-written sequences for timeout, overrun, IRQ clear and mid-operation reset.
module tb_aes_128_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K3       = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] PT2      = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] PT3      = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] PT4      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

    logic ACLK = 1'b0;
    logic ARESET;
    always #5 ACLK = ~ACLK;

    logic           start, key_update, irq_en, irq_clr;
    logic [127:0]   key_in, data_in, result;
    logic           busy, done, err_timeout, err_overrun, irq;
    logic [15:0]    op_count;

    aes_128_ctrl_if cif();

    aes_128_ctrl #(.TIMEOUT_CYCLES(64), .CNT_W(16)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .start       (start),
        .key_in      (key_in),
        .key_update  (key_update),
        .data_in     (data_in),
        .irq_en      (irq_en),
        .irq_clr     (irq_clr),
        .core        (cif),
        .result      (result),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .irq         (irq),
        .op_count    (op_count)
    );

    // Core stand-in: the FIPS-197 vector yields the real ciphertext, anything else a keyed scramble.
    function automatic logic [127:0] stub_ct(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return k ^ {p[63:0], p[127:64]};
    endfunction

    logic       hold_done = 1'b0;
    logic       kbusy, ebusy;
    logic [2:0] kcnt;
    logic [1:0] ecnt;
    int         n_load = 0, n_start = 0;
    int         cyc = 0, start_cyc = 0, cs_cyc = 0;

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (start) start_cyc <= cyc;
        if (cif.core_start) cs_cyc <= cyc;
        if (cif.core_key_load) n_load <= n_load + 1;
        if (cif.core_start) n_start <= n_start + 1;
        if (ARESET) begin
            cif.core_key_ready <= 1'b0;
            cif.core_done      <= 1'b0;
            cif.core_dout      <= '0;
            kbusy <= 1'b0;
            ebusy <= 1'b0;
            kcnt  <= '0;
            ecnt  <= '0;
        end else begin
            if (cif.core_key_load) begin
                cif.core_key_ready <= 1'b0;
                kbusy <= 1'b1;
                kcnt  <= '0;
            end else if (kbusy) begin
                if (kcnt == 3'd3) begin
                    cif.core_key_ready <= 1'b1;
                    kbusy <= 1'b0;
                end else begin
                    kcnt <= kcnt + 3'd1;
                end
            end
            cif.core_done <= 1'b0;
            if (cif.core_start) begin
                ebusy <= !hold_done;
                ecnt  <= '0;
            end else if (ebusy) begin
                if (ecnt == 2'd2) begin
                    cif.core_done <= 1'b1;
                    cif.core_dout <= stub_ct(cif.core_key, cif.core_din);
                    ebusy <= 1'b0;
                end else begin
                    ecnt <= ecnt + 2'd1;
                end
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pulses start and waits for busy to drop; k = negedges from start to idle.
    task automatic run_op(input logic [127:0] pt, input bit clr_on_done, input int ovr_at,
                          output int k);
        data_in = pt;
        start   = 1'b1;
        k = 0;
        do begin
            @(negedge ACLK);
            start   = 1'b0;
            irq_clr = 1'b0;
            k++;
            if (clr_on_done && cif.core_done) irq_clr = 1'b1;
            if (k == ovr_at) start = 1'b1;
        end while (busy && k < 200);
        start   = 1'b0;
        irq_clr = 1'b0;
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic         upd;
        logic [127:0] exp_key;
        int           exp_loads;
        int           exp_lat;
        int           exp_cnt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, l0, s0;
        logic [127:0] r0;

        vecs[0] = '{FIPS_KEY, FIPS_PT, 1'b1, FIPS_KEY, 1, 14, 1};
        vecs[1] = '{FIPS_KEY, PT2,     1'b0, FIPS_KEY, 0, 7,  2};
        vecs[2] = '{K2,       PT2,     1'b1, K2,       1, 14, 3};
        vecs[3] = '{K3,       FIPS_PT, 1'b0, K2,       0, 7,  4};
        vecs[4] = '{FIPS_KEY, FIPS_PT, 1'b1, FIPS_KEY, 1, 14, 5};

        ARESET = 1'b1; start = 1'b0; key_update = 1'b0; irq_en = 1'b0; irq_clr = 1'b0;
        key_in = '0; data_in = '0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("reset_state", 128'({busy, done, err_timeout, err_overrun, irq,
                                 cif.core_key_load, cif.core_start}), 128'd0);
        chk("reset_op_count", 128'(op_count), 128'd0);
        chk("reset_result", result, 128'd0);

        for (int i = 0; i < 5; i++) begin
            l0 = n_load;
            @(negedge ACLK);
            key_in     = vecs[i].key;
            key_update = vecs[i].upd;
            @(negedge ACLK);
            key_update = 1'b0;
            run_op(vecs[i].pt, 1'b0, 0, lat);
            chk($sformatf("v%0d_result", i), result, stub_ct(vecs[i].exp_key, vecs[i].pt));
            chk($sformatf("v%0d_key_loads", i), 128'(n_load - l0), 128'(vecs[i].exp_loads));
            chk($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].exp_lat));
            chk($sformatf("v%0d_op_count", i), 128'(op_count), 128'(vecs[i].exp_cnt));
            chk($sformatf("v%0d_done", i), 128'(done), 128'd1);
            if (vecs[i].exp_loads == 0)
                chk($sformatf("v%0d_start_gap", i), 128'(cs_cyc - start_cyc), 128'd2);
        end

        // start pulsed while the core is encrypting
        s0 = n_start;
        run_op(PT3, 1'b0, 3, lat);
        chk("ovr_flag", 128'(err_overrun), 128'd1);
        chk("ovr_core_starts", 128'(n_start - s0), 128'd1);
        chk("ovr_result", result, stub_ct(FIPS_KEY, PT3));
        chk("ovr_op_count", 128'(op_count), 128'd6);

        // core never answers: abort after the full ENC_WAIT budget
        r0 = result;
        hold_done = 1'b1;
        run_op(PT4, 1'b0, 0, lat);
        hold_done = 1'b0;
        chk("tmo_latency", 128'(lat), 128'd67);
        chk("tmo_flag", 128'(err_timeout), 128'd1);
        chk("tmo_busy", 128'(busy), 128'd0);
        chk("tmo_result_held", result, r0);
        chk("tmo_op_count", 128'(op_count), 128'd6);
        l0 = n_load;
        run_op(PT4, 1'b0, 0, lat);
        chk("tmo_reexpand", 128'(n_load - l0), 128'd1);
        chk("tmo_next_result", result, stub_ct(FIPS_KEY, PT4));

        // IRQ rise/fall timing and clear colliding with capture
        @(negedge ACLK); irq_clr = 1'b1;
        @(negedge ACLK); irq_clr = 1'b0;
        @(negedge ACLK);
        chk("clr_flags", 128'({done, err_timeout, err_overrun}), 128'd0);
        irq_en = 1'b1;
        run_op(FIPS_PT, 1'b0, 0, lat);
        chk("irq_done", 128'(done), 128'd1);
        chk("irq_not_yet", 128'(irq), 128'd0);
        @(negedge ACLK);
        chk("irq_rise", 128'(irq), 128'd1);
        irq_clr = 1'b1;
        @(negedge ACLK);
        irq_clr = 1'b0;
        chk("irq_clr_done", 128'(done), 128'd0);
        chk("irq_still_high", 128'(irq), 128'd1);
        @(negedge ACLK);
        chk("irq_fall", 128'(irq), 128'd0);
        run_op(PT2, 1'b1, 0, lat);
        chk("clr_vs_set_done", 128'(done), 128'd1);
        chk("clr_vs_set_result", result, stub_ct(FIPS_KEY, PT2));

        // reset while waiting on key expansion
        @(negedge ACLK); key_in = K2; key_update = 1'b1;
        @(negedge ACLK); key_update = 1'b0; data_in = FIPS_PT; start = 1'b1;
        @(negedge ACLK); start = 1'b0;
        @(negedge ACLK); ARESET = 1'b1;
        @(negedge ACLK); ARESET = 1'b0;
        chk("rst_mid_flags", 128'({busy, done, err_timeout, err_overrun, irq}), 128'd0);
        chk("rst_mid_op_count", 128'(op_count), 128'd0);
        chk("rst_mid_result", result, 128'd0);
        l0 = n_load;
        run_op(FIPS_PT, 1'b0, 0, lat);
        chk("rst_reexpand", 128'(n_load - l0), 128'd1);
        chk("rst_next_result", result, stub_ct(K2, FIPS_PT));
        chk("rst_next_op_count", 128'(op_count), 128'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
